jtag_uart_sys_led_seq: RTL and testbench
========================================

# jtag_uart_sys_led_seq

Autonomous blink-pattern sequencer for the single-bit LED PIO in `jtag_uart_sys`. The Nios CPU programs a bit pattern, a step period and a pattern length through an Avalon-MM slave. The block then acts as the only master on the LED PIO's `s1` slave, issuing one zero-wait write per step. It runs patterns in loop or one-shot mode, which frees the CPU from LED timing loops.

## Interface
- `PRESCALE_W`, default 24: width of the PERIOD register and step counter.
- `PATTERN_W`, default 16: width of the PATTERN register. Must be a power of two, ≤ 32.
- `clk` in 1: system clock; the only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `address` in 2: slave register select.
- `chipselect` in 1: slave select.
- `write_n` in 1: slave write strobe, active-low.
- `writedata` in 32: slave write data.
- `readdata` out 32: slave read data, combinational, zero wait states.
- `m_chipselect` out 1: to LED PIO `chipselect`.
- `m_write_n` out 1: to LED PIO `write_n`.
- `m_address` out 2: to LED PIO `address`; always 0.
- `m_writedata` out 32: to LED PIO `writedata`; bits [31:1] always 0.

## Operation
Registers:
- **0 CTRL**
  - bit0 EN, R/W.
  - bit1 ONESHOT, R/W.
  - bit2 RESTART, write-1 pulse, reads 0.
  - bit8 BUSY, RO: state ≠ IDLE.
  - bit9 DONE, W1C.
- **1 PERIOD** [PRESCALE_W-1:0]: step length in cycles minus 1. The value 0 is treated as 1.
- **2 PATTERN** [PATTERN_W-1:0]: bit i is the LED value for step i.
- **3 LENGTH** [log2(PATTERN_W)-1:0]: last step index.

Unused read bits return 0. Writes to unused bits are ignored.

FSM states are IDLE, WRITE, WAIT and STOP:
- **IDLE**: master outputs inactive. An EN 0→1 write, or RESTART with EN=1, sets idx=0 and moves to WRITE.
- **WRITE** (1 cycle): drive `m_chipselect`=1, `m_write_n`=0, `m_writedata`={31'b0, PATTERN[idx]}. Load counter with max(PERIOD,1)-1, then go to WAIT.
- **WAIT**: decrement the counter. At 0:
  - idx<LENGTH: idx+1, go to WRITE.
  - idx==LENGTH, ONESHOT=0: idx=0, go to WRITE.
  - idx==LENGTH, ONESHOT=1: go to STOP, set DONE.
- **STOP** (1 cycle): write 0 to the PIO (LED off), clear EN, go to IDLE.

Boundary rules:
- EN cleared by software in WRITE or WAIT → next state is STOP. DONE is not set.
- RESTART in WRITE or WAIT → idx=0, next state is WRITE. DONE is not changed.
- PERIOD, PATTERN, LENGTH and ONESHOT are read live. A new value takes effect at the next counter load or step decision. There is no shadowing.
- A DONE W1C in the same cycle as hardware setting DONE: the set wins.
- EN 0→1 and RESTART in the same write: a single start.

## Timing
- Reset values: all registers 0, state IDLE, `m_chipselect`=0, `m_write_n`=1, `m_address`=0, `m_writedata`=0, `readdata` reflects the zeroed registers.
- The first PIO write occurs in the cycle after the enabling CSR write.
- Consecutive step writes are spaced exactly max(PERIOD,1)+1 cycles apart.
- In one-shot mode, the STOP write follows the last step write by max(PERIOD,1)+1 cycles.
- BUSY drops the cycle after STOP.
- Master strobes last exactly one cycle. The PIO accepts with zero wait states; there is no waitrequest.
- Reset asserted mid-run: all state clears immediately. The master strobe deasserts asynchronously. The LED PIO resets independently.

## Configuration
- `JTAG_UART_SYS_LED_SEQ_IRQ_EN` defined: adds output port `irq` (1 bit). `irq` = DONE & CTRL bit16 IRQ_EN (R/W, reset 0), is registered, and clears the cycle after a DONE W1C.
- Undefined: no `irq` port, and CTRL bit16 reads 0. DONE behaves identically in both builds.

## Structure
- Shared package `jtag_uart_sys_pkg` holds:
  - register address constants;
  - CTRL bit-position constants;
  - the FSM state enum typedef.
- One sub-module, `jtag_uart_sys_led_seq_timer`: a loadable down-counter of width PRESCALE_W with `load`, `value` and `zero` signals.

## Test plan
- Reset: `m_write_n`=1, `m_chipselect`=0, `readdata`=0 at all addresses.
- Loop mode: PERIOD=3, PATTERN=0b1011, LENGTH=3, CTRL=1.
  - Required: PIO writes 1,1,0,1,1,1,… spaced 4 cycles apart.
  - Required: BUSY=1 and DONE stays 0.
- One-shot: PERIOD=0, PATTERN=0b01, LENGTH=1, CTRL=0b11.
  - Required: writes 1,0, then a 0 (STOP) at 2-cycle spacing.
  - Required: DONE=1, EN=0, BUSY=0 afterwards.
- Disable mid-run: clear EN during WAIT.
  - Required: 0 written next cycle, then IDLE with DONE=0.
- RESTART during step 2 of a 4-step loop: next write is PATTERN[0], issued the following cycle.
- IRQ build: finish a one-shot with IRQ_EN=1 → `irq` rises. Writing CTRL bit9=1 drops it the next cycle.

Source files
------------

// File: rtl/jtag_uart_sys_pkg.sv
// Shared definitions for the jtag_uart_sys LED blink sequencer:
// CSR addresses, CTRL bit positions and the sequencer state encoding.
package jtag_uart_sys_pkg;

  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_PERIOD  = 2'd1;
  localparam logic [1:0] ADDR_PATTERN = 2'd2;
  localparam logic [1:0] ADDR_LENGTH  = 2'd3;

  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_ONESHOT_BIT = 1;
  localparam int CTRL_RESTART_BIT = 2;
  localparam int CTRL_BUSY_BIT    = 8;
  localparam int CTRL_DONE_BIT    = 9;
  localparam int CTRL_IRQ_EN_BIT  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_STOP  = 2'd3
  } led_seq_state_e;

endpackage

// File: rtl/jtag_uart_sys_led_seq_timer.sv
// Loadable down-counter that times one blink step. Loading wins over
// decrementing; the count holds at zero until the next load.
module jtag_uart_sys_led_seq_timer #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_load,
  input  logic         i_dec,
  input  logic [W-1:0] i_value,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // Count register: load a fresh step length or count down towards zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/jtag_uart_sys_led_seq.sv
// Autonomous blink-pattern sequencer driving the single-bit LED PIO.
// The CPU programs PERIOD / PATTERN / LENGTH / CTRL over an Avalon-MM
// slave; the block then issues one zero-wait PIO write per step.
// Optional build macro JTAG_UART_SYS_LED_SEQ_IRQ_EN adds the irq output
// and the CTRL IRQ_EN bit (bit 16).
//
// Bus handshake: the slave has zero wait states -- a write is taken in
// every cycle where chipselect=1 and write_n=0, and readdata is a pure
// function of address. The master strobe (m_chipselect=1, m_write_n=0)
// lasts exactly one cycle and is always accepted by the PIO.
module jtag_uart_sys_led_seq
  import jtag_uart_sys_pkg::*;
#(
  parameter int PRESCALE_W = 24,
  parameter int PATTERN_W  = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [1:0]     address,
  input  logic           chipselect,
  input  logic           write_n,
  input  logic [31:0]    writedata,
  output logic [31:0]    readdata,
  output logic           m_chipselect,
  output logic           m_write_n,
  output logic [1:0]     m_address,
  output logic [31:0]    m_writedata,
`ifdef JTAG_UART_SYS_LED_SEQ_IRQ_EN
  output logic           irq,
`endif
  output led_seq_state_e o_dbg_state
);

  localparam int LW = (PATTERN_W > 1) ? $clog2(PATTERN_W) : 1;

  // CSR state
  logic                  r_en;
  logic                  r_oneshot;
  logic                  r_done;
  logic [PRESCALE_W-1:0] r_period;
  logic [PATTERN_W-1:0]  r_pattern;
  logic [LW-1:0]         r_length;
`ifdef JTAG_UART_SYS_LED_SEQ_IRQ_EN
  logic                  r_irq_en;
  logic                  r_irq;
  logic                  w_irq_en_nxt;
`endif

  // Sequencer state
  led_seq_state_e        r_state;
  logic [LW-1:0]         r_idx;
  logic                  r_m_cs;
  logic                  r_m_wn;
  logic                  r_m_data;

  logic                  w_wr_ctrl;
  logic                  w_active;
  logic                  w_start;
  logic                  w_sw_stop;
  logic                  w_sw_restart;
  logic                  w_last;
  logic                  w_cnt_zero;
  logic                  w_done_set;
  logic                  w_done_nxt;
  logic [LW-1:0]         w_idx_inc;
  logic [PRESCALE_W-1:0] w_load_val;
  logic                  w_unused;

  assign w_wr_ctrl = chipselect && !write_n && (address == ADDR_CTRL);
  assign w_active  = (r_state == ST_WRITE) || (r_state == ST_WAIT);

  // EN rising (or EN+RESTART in one write) starts once; EN is never 1 in IDLE.
  assign w_start = w_wr_ctrl && (r_state == ST_IDLE) && writedata[CTRL_EN_BIT] &&
                   (!r_en || writedata[CTRL_RESTART_BIT]);
  // Clearing EN while running forces the LED-off write; it beats RESTART.
  assign w_sw_stop    = w_wr_ctrl && w_active && !writedata[CTRL_EN_BIT];
  assign w_sw_restart = w_wr_ctrl && w_active && writedata[CTRL_EN_BIT] &&
                        writedata[CTRL_RESTART_BIT];

  assign w_last     = (r_idx == r_length);
  assign w_idx_inc  = r_idx + 1'b1;
  // A PERIOD of 0 behaves like 1: the counter is loaded with max(PERIOD,1)-1.
  assign w_load_val = (r_period == '0) ? '0 : (r_period - 1'b1);

  assign w_done_set = (r_state == ST_WAIT) && w_cnt_zero && w_last && r_oneshot &&
                      !w_sw_stop && !w_sw_restart;
  // Hardware set beats a simultaneous software W1C.
  assign w_done_nxt = w_done_set ||
                      (r_done && !(w_wr_ctrl && writedata[CTRL_DONE_BIT]));

  // Only some writedata bits are architectural; the rest are ignored.
  assign w_unused = ^writedata;

  jtag_uart_sys_led_seq_timer #(
    .W (PRESCALE_W)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (r_state == ST_WRITE),
    .i_dec   (r_state == ST_WAIT),
    .i_value (w_load_val),
    .o_zero  (w_cnt_zero)
  );

`ifdef JTAG_UART_SYS_LED_SEQ_IRQ_EN
  assign w_irq_en_nxt = w_wr_ctrl ? writedata[CTRL_IRQ_EN_BIT] : r_irq_en;
`endif

  // CSR writes; STOP clears EN in hardware.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_en      <= 1'b0;
      r_oneshot <= 1'b0;
      r_done    <= 1'b0;
      r_period  <= '0;
      r_pattern <= '0;
      r_length  <= '0;
`ifdef JTAG_UART_SYS_LED_SEQ_IRQ_EN
      r_irq_en  <= 1'b0;
      r_irq     <= 1'b0;
`endif
    end else begin
      r_done <= w_done_nxt;
      if (r_state == ST_STOP) begin
        r_en <= 1'b0;
      end else if (w_wr_ctrl) begin
        r_en <= writedata[CTRL_EN_BIT];
      end
      if (w_wr_ctrl) begin
        r_oneshot <= writedata[CTRL_ONESHOT_BIT];
      end
      if (chipselect && !write_n) begin
        case (address)
          ADDR_PERIOD:  r_period  <= writedata[PRESCALE_W-1:0];
          ADDR_PATTERN: r_pattern <= writedata[PATTERN_W-1:0];
          ADDR_LENGTH:  r_length  <= writedata[LW-1:0];
          default:      ;
        endcase
      end
`ifdef JTAG_UART_SYS_LED_SEQ_IRQ_EN
      r_irq_en <= w_irq_en_nxt;
      r_irq    <= w_done_nxt && w_irq_en_nxt;
`endif
    end
  end

  // Sequencer FSM with registered one-cycle master strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_m_cs   <= 1'b0;
      r_m_wn   <= 1'b1;
      r_m_data <= 1'b0;
    end else begin
      r_m_cs   <= 1'b0;
      r_m_wn   <= 1'b1;
      r_m_data <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_idx    <= '0;
            r_state  <= ST_WRITE;
            r_m_cs   <= 1'b1;
            r_m_wn   <= 1'b0;
            r_m_data <= r_pattern[0];
          end
        end
        ST_WRITE, ST_WAIT: begin
          if (w_sw_stop) begin
            r_state <= ST_STOP;
            r_m_cs  <= 1'b1;
            r_m_wn  <= 1'b0;
          end else if (w_sw_restart) begin
            r_idx    <= '0;
            r_state  <= ST_WRITE;
            r_m_cs   <= 1'b1;
            r_m_wn   <= 1'b0;
            r_m_data <= r_pattern[0];
          end else if (r_state == ST_WRITE) begin
            r_state <= ST_WAIT;
          end else if (w_cnt_zero) begin
            r_m_cs <= 1'b1;
            r_m_wn <= 1'b0;
            if (!w_last) begin
              r_idx    <= w_idx_inc;
              r_state  <= ST_WRITE;
              r_m_data <= r_pattern[w_idx_inc];
            end else if (!r_oneshot) begin
              r_idx    <= '0;
              r_state  <= ST_WRITE;
              r_m_data <= r_pattern[0];
            end else begin
              r_state <= ST_STOP;
            end
          end
        end
        ST_STOP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Zero-wait read mux; unused bits read 0.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL: begin
        readdata[CTRL_EN_BIT]      = r_en;
        readdata[CTRL_ONESHOT_BIT] = r_oneshot;
        readdata[CTRL_BUSY_BIT]    = (r_state != ST_IDLE);
        readdata[CTRL_DONE_BIT]    = r_done;
`ifdef JTAG_UART_SYS_LED_SEQ_IRQ_EN
        readdata[CTRL_IRQ_EN_BIT]  = r_irq_en;
`endif
      end
      ADDR_PERIOD:  readdata[PRESCALE_W-1:0] = r_period;
      ADDR_PATTERN: readdata[PATTERN_W-1:0]  = r_pattern;
      ADDR_LENGTH:  readdata[LW-1:0]         = r_length;
      default:      ;
    endcase
  end

  assign m_chipselect = r_m_cs;
  assign m_write_n    = r_m_wn;
  assign m_address    = 2'b00;
  assign m_writedata  = {31'b0, r_m_data};
  assign o_dbg_state  = r_state;
`ifdef JTAG_UART_SYS_LED_SEQ_IRQ_EN
  assign irq = r_irq;
`endif

endmodule

// File: tb/tb_jtag_uart_sys_led_seq.sv
// Bench for jtag_uart_sys_led_seq: CSR vector table plus timed blink
// sequences checked against a queue of expected {cycle, address, data}
// PIO writes.
module tb_jtag_uart_sys_led_seq;
  import jtag_uart_sys_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic [1:0]     address = '0;
  logic           chipselect = 1'b0;
  logic           write_n = 1'b1;
  logic [31:0]    writedata = '0;
  logic [31:0]    readdata;
  logic           m_chipselect;
  logic           m_write_n;
  logic [1:0]     m_address;
  logic [31:0]    m_writedata;
  led_seq_state_e dbg_state;
`ifdef JTAG_UART_SYS_LED_SEQ_IRQ_EN
  logic           irq;
  localparam logic [31:0] IRQ_BIT = 32'h0001_0000;
`else
  localparam logic [31:0] IRQ_BIT = 32'h0000_0000;
`endif

  jtag_uart_sys_led_seq dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .address      (address),
    .chipselect   (chipselect),
    .write_n      (write_n),
    .writedata    (writedata),
    .readdata     (readdata),
    .m_chipselect (m_chipselect),
    .m_write_n    (m_write_n),
    .m_address    (m_address),
    .m_writedata  (m_writedata),
`ifdef JTAG_UART_SYS_LED_SEQ_IRQ_EN
    .irq          (irq),
`endif
    .o_dbg_state  (dbg_state)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // ---------------- scoreboard ----------------
  // Entry: {cycle[31:0], m_address[1:0], m_writedata[31:0]}
  logic [65:0] exp_q[$];
  logic [65:0] mon_exp;
  logic [65:0] mon_act;

  task automatic push_wr(input int cy, input logic b);
    exp_q.push_back({32'(cy), 2'b00, 31'b0, b});
  endtask

  always @(negedge clk) begin
    if (reset_n && m_chipselect && !m_write_n) begin
      n_vec++;
      mon_act = {32'(cyc), m_address, m_writedata};
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL sb_unexpected: got write data %h at cycle %0d, required no write",
                 m_writedata, cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp)
          $display("FAIL sb_write: got cycle %0d addr %0d data %h, required cycle %0d addr %0d data %h",
                   mon_act[65:34], mon_act[33:32], mon_act[31:0],
                   mon_exp[65:34], mon_exp[33:32], mon_exp[31:0]);
        if (mon_act !== mon_exp) n_miss++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Called at a negedge; the write is taken at the following posedge.
  task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic csr_read(input logic [1:0] a, output logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = a;
    #1 d = readdata;
    chipselect = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
    if (cyc != t) begin
      n_miss++;
      $display("FAIL schedule: got cycle %0d, required cycle %0d", cyc, t);
    end
  endtask

  task automatic drain_check(input string name);
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // ---------------- CSR vector table ----------------
  typedef struct {
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[8];

  // ---------------- main test ----------------
  initial begin
    logic [31:0] rd;
    logic [3:0]  pat;
    int          c;

    vecs[0] = '{ADDR_PERIOD,  32'hFFFF_FFFF, 32'h00FF_FFFF,         "period_mask"};
    vecs[1] = '{ADDR_PERIOD,  32'h0000_0000, 32'h0000_0000,         "period_zero"};
    vecs[2] = '{ADDR_PATTERN, 32'hDEAD_BEEF, 32'h0000_BEEF,         "pattern_mask"};
    vecs[3] = '{ADDR_LENGTH,  32'hFFFF_FFF7, 32'h0000_0007,         "length_mask"};
    vecs[4] = '{ADDR_LENGTH,  32'h0000_0010, 32'h0000_0000,         "length_wrap"};
    vecs[5] = '{ADDR_CTRL,    32'h0000_0002, 32'h0000_0002,         "ctrl_oneshot"};
    vecs[6] = '{ADDR_CTRL,    32'hFFFF_FFFA, 32'h0000_0002 | IRQ_BIT, "ctrl_ro_bits"};
    vecs[7] = '{ADDR_CTRL,    32'h0000_0004, 32'h0000_0000,         "ctrl_restart_no_en"};

    // Reset
    repeat (3) @(negedge clk);
    check("rst_async_cs", {31'b0, m_chipselect}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_write_n", {31'b0, m_write_n}, 32'd1);
    check("rst_cs", {31'b0, m_chipselect}, 32'd0);
    check("rst_m_addr_data", {30'b0, m_address} | m_writedata, 32'd0);
    for (int a = 0; a < 4; a++) begin
      csr_read(a[1:0], rd);
      check($sformatf("rst_read_%0d", a), rd, 32'd0);
    end
    @(negedge clk);

    // CSR table
    for (int i = 0; i < 8; i++) begin
      csr_write(vecs[i].addr, vecs[i].wdata);
      csr_read(vecs[i].addr, rd);
      check(vecs[i].name, rd, vecs[i].exp);
    end
    csr_write(ADDR_CTRL, 32'h0);
    drain_check("table_no_pio_write");

    // Loop mode: PERIOD=3, PATTERN=1011, LENGTH=3
    csr_write(ADDR_PERIOD, 32'd3);
    csr_write(ADDR_PATTERN, 32'b1011);
    csr_write(ADDR_LENGTH, 32'd3);
    c   = cyc;
    pat = 4'b1011;
    for (int n = 0; n < 10; n++) push_wr(c + 1 + 4 * n, pat[n % 4]);
    push_wr(c + 39, 1'b0);
    csr_write(ADDR_CTRL, 32'h1);
    wait_until(c + 20);
    csr_read(ADDR_CTRL, rd);
    check("loop_busy_no_done", rd, 32'h0000_0101);
    wait_until(c + 38);
    csr_write(ADDR_CTRL, 32'h0);
    wait_until(c + 41);
    csr_read(ADDR_CTRL, rd);
    check("disable_idle_no_done", rd, 32'h0);
    check("disable_dbg_idle", 32'(dbg_state), 32'(ST_IDLE));
    drain_check("loop_drain");

    // One-shot: PERIOD=0, PATTERN=01, LENGTH=1
    csr_write(ADDR_PERIOD, 32'd0);
    csr_write(ADDR_PATTERN, 32'b01);
    csr_write(ADDR_LENGTH, 32'd1);
    c = cyc;
    push_wr(c + 1, 1'b1);
    push_wr(c + 3, 1'b0);
    push_wr(c + 5, 1'b0);
    csr_write(ADDR_CTRL, 32'h3 | IRQ_BIT);
    wait_until(c + 7);
    csr_read(ADDR_CTRL, rd);
    check("oneshot_done", rd, 32'h0000_0202 | IRQ_BIT);
`ifdef JTAG_UART_SYS_LED_SEQ_IRQ_EN
    check("irq_rise", {31'b0, irq}, 32'd1);
`endif
    wait_until(c + 8);
    csr_write(ADDR_CTRL, 32'h0000_0202 | IRQ_BIT);
`ifdef JTAG_UART_SYS_LED_SEQ_IRQ_EN
    check("irq_drop", {31'b0, irq}, 32'd0);
`endif
    csr_read(ADDR_CTRL, rd);
    check("done_w1c", rd, 32'h0000_0002 | IRQ_BIT);
    csr_write(ADDR_CTRL, 32'h0);
    drain_check("oneshot_drain");

    // RESTART during step 2 of a 4-step loop; EN+RESTART start is single
    csr_write(ADDR_PERIOD, 32'd3);
    csr_write(ADDR_PATTERN, 32'b1001);
    csr_write(ADDR_LENGTH, 32'd3);
    c = cyc;
    push_wr(c + 1,  1'b1);
    push_wr(c + 5,  1'b0);
    push_wr(c + 9,  1'b0);
    push_wr(c + 11, 1'b1);
    push_wr(c + 15, 1'b0);
    push_wr(c + 19, 1'b0);
    push_wr(c + 23, 1'b1);
    push_wr(c + 25, 1'b0);
    csr_write(ADDR_CTRL, 32'h5);
    wait_until(c + 10);
    csr_write(ADDR_CTRL, 32'h5);
    wait_until(c + 24);
    csr_write(ADDR_CTRL, 32'h0);
    wait_until(c + 27);
    csr_read(ADDR_CTRL, rd);
    check("restart_end_idle", rd, 32'h0);
    drain_check("restart_drain");

    // Reset asserted mid-run while the strobe is high
    csr_write(ADDR_PERIOD, 32'd5);
    csr_write(ADDR_PATTERN, 32'h1);
    csr_write(ADDR_LENGTH, 32'h0);
    c = cyc;
    push_wr(c + 1, 1'b1);
    csr_write(ADDR_CTRL, 32'h1);
    wait_until(c + 1);
    #2 reset_n = 1'b0;
    #1;
    check("midrun_rst_cs", {31'b0, m_chipselect}, 32'd0);
    check("midrun_rst_wn", {31'b0, m_write_n}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    csr_read(ADDR_CTRL, rd);
    check("midrun_rst_ctrl", rd, 32'h0);
    csr_read(ADDR_PATTERN, rd);
    check("midrun_rst_pattern", rd, 32'h0);
    repeat (8) @(negedge clk);
    drain_check("midrun_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Watchdog so the run always ends with a summary.
  initial begin
    #200000;
    n_miss++;
    $display("FAIL watchdog: got no completion by %0t, required completion", $time);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
